// File: rtl/clk_ctrl_pkg.sv
// Shared constants for the CPU clock-enable generator: mode encoding and
// default timing for a 12 MHz board clock.
package clk_ctrl_pkg;

    localparam int unsigned MODE_W   = 2;
    localparam int unsigned EN_CNT_W = 8;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 240000;
    localparam int unsigned DIV_1HZ_DEF         = 12000000;
    localparam int unsigned DIV_10HZ_DEF        = 1200000;
    localparam int unsigned CNT_W_DEF           = 24;

    typedef enum logic [MODE_W-1:0] {
        MODE_STEP = 2'b00,
        MODE_1HZ  = 2'b01,
        MODE_10HZ = 2'b10,
        MODE_FULL = 2'b11
    } mode_e;

endpackage

// File: rtl/btn_step_detect.sv
// Step button front end: 2-FF synchroniser, debounce counter and press-edge
// detector producing a registered one-cycle step pulse.
module btn_step_detect #(
    parameter int unsigned DEBOUNCE_CYCLES = 240000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic clk,
    input  logic rstN,
    input  logic btn_i,
`ifdef CPU_CLK_EN_GEN_AUTOREPEAT_EN
    output logic btn_db_o,
`endif
    output logic step_pulse_o
);

    logic [1:0]       sync_q;
    logic             db_q;
    logic             db_d;
    logic             db_prev_q;
    logic             pulse_q;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] db_cnt_d;

    // Accept a level change only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync_q[1] != db_q) begin
            if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_q    <= 2'b11;
            db_q      <= 1'b1;
            db_prev_q <= 1'b1;
            db_cnt_q  <= '0;
            pulse_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            db_q      <= db_d;
            db_cnt_q  <= db_cnt_d;
            db_prev_q <= db_q;
            pulse_q   <= db_prev_q & ~db_q;
        end
    end

`ifdef CPU_CLK_EN_GEN_AUTOREPEAT_EN
    assign btn_db_o     = db_q;
`endif
    assign step_pulse_o = pulse_q;

endmodule

// File: rtl/cpu_clk_en_gen.sv
// CPU clock-enable generator: merges step button, 1 Hz, 10 Hz and full-speed
// sources into a registered one-cycle enable. Optional hold-to-repeat in STEP
// mode is built when CPU_CLK_EN_GEN_AUTOREPEAT_EN is defined.
module cpu_clk_en_gen
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned DIV_1HZ         = DIV_1HZ_DEF,
    parameter int unsigned DIV_10HZ        = DIV_10HZ_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                clkBtn,
    input  logic [MODE_W-1:0]   clkSel,
    output logic                cpuClkEn,
    output logic [MODE_W-1:0]   modeOut,
    output logic [EN_CNT_W-1:0] enCount
);

    logic [MODE_W-1:0]   sel_s1_q;
    logic [MODE_W-1:0]   sel_s2_q;
    mode_e               mode_q;
    mode_e               sel_mode;
    logic [CNT_W-1:0]    div_cnt_q;
    logic [CNT_W-1:0]    div_lim;
    logic                div_run;
    logic                tick_c;
    logic                switch_c;
    logic                step_pulse;
    logic                en_q;
    logic [EN_CNT_W-1:0] en_cnt_q;
`ifdef CPU_CLK_EN_GEN_AUTOREPEAT_EN
    logic                btn_db;
    logic                rep_fast_q;
`endif

    btn_step_detect #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn (
        .clk          (clk),
        .rstN         (rstN),
        .btn_i        (clkBtn),
`ifdef CPU_CLK_EN_GEN_AUTOREPEAT_EN
        .btn_db_o     (btn_db),
`endif
        .step_pulse_o (step_pulse)
    );

    assign sel_mode = mode_e'(sel_s2_q);
    assign switch_c = (sel_mode != mode_q);

    // Prescaler limit and run condition for the active mode.
    always_comb begin
        div_run = 1'b0;
        div_lim = '0;
        case (mode_q)
            MODE_1HZ: begin
                div_run = 1'b1;
                div_lim = CNT_W'(DIV_1HZ - 1);
            end
            MODE_10HZ: begin
                div_run = 1'b1;
                div_lim = CNT_W'(DIV_10HZ - 1);
            end
`ifdef CPU_CLK_EN_GEN_AUTOREPEAT_EN
            // Repeat timer restarts on the press pulse so the first repeat lands DIV_1HZ later.
            MODE_STEP: begin
                div_run = ~btn_db & ~step_pulse;
                div_lim = rep_fast_q ? CNT_W'(DIV_10HZ - 1) : CNT_W'(DIV_1HZ - 1);
            end
`endif
            default: ;
        endcase
    end

    assign tick_c = div_run && (div_cnt_q == div_lim);

    // Mode FSM, prescaler and enable register; a switch cycle always suppresses the enable.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sel_s1_q   <= '0;
            sel_s2_q   <= '0;
            mode_q     <= MODE_STEP;
            div_cnt_q  <= '0;
            en_q       <= 1'b0;
            en_cnt_q   <= '0;
`ifdef CPU_CLK_EN_GEN_AUTOREPEAT_EN
            rep_fast_q <= 1'b0;
`endif
        end else begin
            sel_s1_q <= clkSel;
            sel_s2_q <= sel_s1_q;
            en_cnt_q <= en_cnt_q + EN_CNT_W'(en_q);
            if (switch_c) begin
                mode_q     <= sel_mode;
                div_cnt_q  <= '0;
                en_q       <= 1'b0;
`ifdef CPU_CLK_EN_GEN_AUTOREPEAT_EN
                rep_fast_q <= 1'b0;
`endif
            end else begin
                div_cnt_q <= (!div_run || tick_c) ? '0 : div_cnt_q + CNT_W'(1);
                case (mode_q)
`ifdef CPU_CLK_EN_GEN_AUTOREPEAT_EN
                    MODE_STEP: en_q <= step_pulse | tick_c;
`else
                    MODE_STEP: en_q <= step_pulse;
`endif
                    MODE_1HZ:  en_q <= tick_c;
                    MODE_10HZ: en_q <= tick_c;
                    MODE_FULL: en_q <= 1'b1;
                    default:   en_q <= 1'b0;
                endcase
`ifdef CPU_CLK_EN_GEN_AUTOREPEAT_EN
                if (btn_db) begin
                    rep_fast_q <= 1'b0;
                end else if (mode_q == MODE_STEP && tick_c) begin
                    rep_fast_q <= 1'b1;
                end
`endif
            end
        end
    end

    assign cpuClkEn = en_q;
    assign modeOut  = mode_q;
    assign enCount  = en_cnt_q;

endmodule

// File: tb/tb_cpu_clk_en_gen.sv
// Scoreboard bench for cpu_clk_en_gen with short debounce/divider settings.
module tb_cpu_clk_en_gen;
    import clk_ctrl_pkg::*;

`ifdef CPU_CLK_EN_GEN_AUTOREPEAT_EN
    localparam int STEP_PULSES = 9;
`else
    localparam int STEP_PULSES = 1;
`endif

    logic       clk      = 1'b0;
    logic       rstN     = 1'b1;
    logic       clkBtn   = 1'b1;
    logic [1:0] clkSel   = 2'b00;
    logic       cpuClkEn;
    logic [1:0] modeOut;
    logic [7:0] enCount;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_cnt  = 0;
    int exp_q[$];
    bit mon_exp;

    cpu_clk_en_gen #(
        .DEBOUNCE_CYCLES (4),
        .DIV_1HZ         (20),
        .DIV_10HZ        (5),
        .CNT_W           (24)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .clkBtn   (clkBtn),
        .clkSel   (clkSel),
        .cpuClkEn (cpuClkEn),
        .modeOut  (modeOut),
        .enCount  (enCount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Per-cycle scoreboard: expected enable cycles are queued by the stimulus.
    always @(posedge clk) begin
        #1;
        if (!rstN) begin
            exp_cnt = 0;
        end else begin
            mon_exp = (exp_q.size() > 0) && (exp_q[0] == cyc);
            if (mon_exp) void'(exp_q.pop_front());
            check_eq("cpuClkEn", int'(cpuClkEn), int'(mon_exp));
            check_eq("enCount_track", int'(enCount), exp_cnt);
            if (mon_exp) exp_cnt = (exp_cnt + 1) % 256;
        end
    end

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        #1;
        check_eq("rst_cpuClkEn", int'(cpuClkEn), 0);
        check_eq("rst_modeOut", int'(modeOut), 0);
        check_eq("rst_enCount", int'(enCount), 0);
        exp_q.delete();
        clkBtn = 1'b1;
        clkSel = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        int g;
        #2;
        rstN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("init_cpuClkEn", int'(cpuClkEn), 0);
        check_eq("init_modeOut", int'(modeOut), 0);
        check_eq("init_enCount", int'(enCount), 0);
        rstN = 1'b1;

        // Idle after reset: no enables for 100 cycles.
        c = cyc;
        wait_to(c + 100);
        check_eq("idle_enCount", int'(enCount), 0);

        // Step press held 60 cycles.
        c = cyc;
        clkBtn = 1'b0;
        exp_q.push_back(c + 8);
`ifdef CPU_CLK_EN_GEN_AUTOREPEAT_EN
        for (int k = 0; k < 8; k++) exp_q.push_back(c + 28 + 5 * k);
`endif
        wait_to(c + 60);
        clkBtn = 1'b1;
        wait_to(c + 80);
        check_eq("step_enCount", int'(enCount), STEP_PULSES);
        check_eq("step_pending", exp_q.size(), 0);

        // 3-cycle button glitch is filtered.
        c = cyc;
        clkBtn = 1'b0;
        wait_to(c + 3);
        clkBtn = 1'b1;
        wait_to(c + 30);
        check_eq("glitch_enCount", int'(enCount), STEP_PULSES);

        // 10 Hz mode: first pulse 6 cycles after the switch cycle, then every 5.
        do_reset();
        c = cyc;
        clkSel = 2'b10;
        for (int i = 0; i < 20; i++) exp_q.push_back(c + 8 + 5 * i);
        wait_to(c + 2);
        check_eq("hz10_mode_early", int'(modeOut), 0);
        wait_to(c + 3);
        check_eq("hz10_mode", int'(modeOut), int'(MODE_10HZ));
        wait_to(c + 104);
        check_eq("hz10_enCount", int'(enCount), 20);
        check_eq("hz10_pending", exp_q.size(), 0);

        // 1 Hz mode, switch to 10 Hz with divCnt=15; no stale 1 Hz tick.
        do_reset();
        c = cyc;
        clkSel = 2'b01;
        wait_to(c + 3);
        check_eq("hz1_mode", int'(modeOut), int'(MODE_1HZ));
        wait_to(c + 16);
        clkSel = 2'b10;
        exp_q.push_back(c + 24);
        exp_q.push_back(c + 29);
        exp_q.push_back(c + 34);
        wait_to(c + 18);
        check_eq("mid_mode_hold", int'(modeOut), int'(MODE_1HZ));
        wait_to(c + 19);
        check_eq("mid_mode_new", int'(modeOut), int'(MODE_10HZ));
        wait_to(c + 35);
        check_eq("mid_enCount", int'(enCount), 3);
        check_eq("mid_pending", exp_q.size(), 0);

        // Full speed: 0 in the switch cycle, then every cycle; 300 enables wrap to 44.
        do_reset();
        c = cyc;
        clkSel = 2'b11;
        for (int i = 4; i <= 304; i++) exp_q.push_back(c + i);
        wait_to(c + 3);
        check_eq("full_mode", int'(modeOut), int'(MODE_FULL));
        wait_to(c + 304);
        check_eq("full_enCount_wrap", int'(enCount), 44);

        // One-cycle clkSel glitch: two switches, each with its dead cycle.
        g = cyc;
        clkSel = 2'b10;
        exp_q.push_back(g + 1);
        exp_q.push_back(g + 2);
        for (int i = 5; i <= 9; i++) exp_q.push_back(g + i);
        wait_to(g + 1);
        clkSel = 2'b11;
        wait_to(g + 3);
        check_eq("sel_glitch_mode1", int'(modeOut), int'(MODE_10HZ));
        wait_to(g + 4);
        check_eq("sel_glitch_mode2", int'(modeOut), int'(MODE_FULL));
        wait_to(g + 9);
        check_eq("sel_glitch_pending", exp_q.size(), 0);

        // Reset while enabling at full speed.
        do_reset();
        c = cyc;
        wait_to(c + 20);
        check_eq("final_enCount", int'(enCount), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
